link_eoverp_rx: RTL and testbench

- Receive end of the Ethernet-over-power pair link.
- Samples the four TIA-568B conductor levels (pair 1236 as 12/36, pair 5478 as 54/78) once per clock and decodes one dibit per cycle.
- Hunts for preamble and start delimiter, deserializes data bytes and checks the trailing checksum byte.
- Sits after the post-LNA pair split; delivers a byte stream plus per-frame status to the link controller.

---
 rtl/link_eoverp_rx.sv | 140 ++++++++++++++
 tb/tb_link_eoverp_rx.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/link_eoverp_rx.sv
// Receive side of the Ethernet-over-power pair link: decodes one dibit per clock,
// hunts preamble/start delimiter, deserializes bytes and checks the trailing checksum.
module link_eoverp_rx #(
  parameter int MinPreamble   = 8,
  parameter int MaxFrameBytes = 64
) (
  input  logic       Clock100Mhz,
  input  logic       Reset,
  input  logic       TIA_568B12,
  input  logic       TIA_568B36,
  input  logic       TIA_568B54,
  input  logic       TIA_568B78,
  output logic [7:0] RxByte,
  output logic       RxValid,
  output logic       FrameDone,
  output logic       FrameGood,
  output logic [7:0] FrameBytes,
  output logic [7:0] CodeViolations
);

  localparam logic [7:0] MAX_BYTES = 8'(MaxFrameBytes);
  localparam logic [7:0] MIN_PRE   = 8'(MinPreamble);

  typedef enum logic [1:0] {IDLE, PREAMBLE, DATA, ERROR} state_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Stage p0: combinational line decode of the sampled conductor levels
  logic       active_p0, idle_p0, fault_p0;
  logic [1:0] dibit_p0;

  always_comb begin
    active_p0 = (TIA_568B12 ^ TIA_568B36) & (TIA_568B54 ^ TIA_568B78);
    idle_p0   = ~(TIA_568B12 | TIA_568B36 | TIA_568B54 | TIA_568B78);
    fault_p0  = ~active_p0 & ~idle_p0;
    dibit_p0  = {TIA_568B54, TIA_568B12};
  end

  state_t     state;
  logic [7:0] pre_cnt;
  logic [1:0] phase;
  logic [5:0] shreg;
  logic [7:0] byte_cnt;
  logic [7:0] sum;
  logic [7:0] prev_sum;
  logic [7:0] last_byte;
  logic [7:0] byte_p0;

  assign byte_p0 = {dibit_p0, shreg};

  // Stage p1: frame state machine with registered byte and status outputs
  always_ff @(posedge Clock100Mhz or posedge Reset) begin
    if (Reset) begin
      state          <= IDLE;
      pre_cnt        <= '0;
      phase          <= '0;
      shreg          <= '0;
      byte_cnt       <= '0;
      sum            <= '0;
      prev_sum       <= '0;
      last_byte      <= '0;
      RxByte         <= '0;
      RxValid        <= 1'b0;
      FrameDone      <= 1'b0;
      FrameGood      <= 1'b0;
      FrameBytes     <= '0;
      CodeViolations <= '0;
    end else begin
      RxValid   <= 1'b0;
      FrameDone <= 1'b0;
      case (state)
        IDLE: begin
          if (active_p0 && dibit_p0 == 2'b01) begin
            state    <= PREAMBLE;
            pre_cnt  <= 8'd1;
            byte_cnt <= '0;
          end
        end
        PREAMBLE: begin
          if (idle_p0) begin
            state <= IDLE;
          end else if (active_p0 && dibit_p0 == 2'b01) begin
            pre_cnt <= sat_inc8(pre_cnt);
          end else if (active_p0 && dibit_p0 == 2'b11 && pre_cnt >= MIN_PRE) begin
            state    <= DATA;
            phase    <= '0;
            byte_cnt <= '0;
            sum      <= '0;
            prev_sum <= '0;
          end else begin
            if (fault_p0) CodeViolations <= sat_inc8(CodeViolations);
            state      <= ERROR;
            FrameDone  <= 1'b1;
            FrameGood  <= 1'b0;
            FrameBytes <= byte_cnt;
          end
        end
        DATA: begin
          if (idle_p0 && phase == 2'd0) begin
            state      <= IDLE;
            FrameDone  <= 1'b1;
            FrameGood  <= (byte_cnt >= 8'd2) && (prev_sum == last_byte);
            FrameBytes <= byte_cnt;
          end else if (!active_p0) begin
            if (fault_p0) CodeViolations <= sat_inc8(CodeViolations);
            state      <= ERROR;
            FrameDone  <= 1'b1;
            FrameGood  <= 1'b0;
            FrameBytes <= byte_cnt;
          end else begin
            phase <= phase + 2'd1;
            shreg <= {dibit_p0, shreg[5:2]};
            if (phase == 2'd3) begin
              if (byte_cnt == MAX_BYTES) begin
                state      <= ERROR;
                FrameDone  <= 1'b1;
                FrameGood  <= 1'b0;
                FrameBytes <= byte_cnt;
              end else begin
                RxByte    <= byte_p0;
                RxValid   <= 1'b1;
                byte_cnt  <= byte_cnt + 8'd1;
                prev_sum  <= sum;
                sum       <= sum + byte_p0;
                last_byte <= byte_p0;
              end
            end
          end
        end
        ERROR: begin
          if (idle_p0) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_link_eoverp_rx.sv
// Directed bench for link_eoverp_rx: two instances (MaxFrameBytes 64 and 4) share the line.
module tb_link_eoverp_rx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic l12, l36, l54, l78;

  logic [7:0] rx_byte, frame_bytes, code_viol;
  logic       rx_valid, frame_done, frame_good;
  logic [7:0] rx_byte4, frame_bytes4, code_viol4;
  logic       rx_valid4, frame_done4, frame_good4;

  link_eoverp_rx #(.MinPreamble(8), .MaxFrameBytes(64)) dut (
    .Clock100Mhz(clk), .Reset(rst),
    .TIA_568B12(l12), .TIA_568B36(l36), .TIA_568B54(l54), .TIA_568B78(l78),
    .RxByte(rx_byte), .RxValid(rx_valid), .FrameDone(frame_done),
    .FrameGood(frame_good), .FrameBytes(frame_bytes), .CodeViolations(code_viol)
  );

  link_eoverp_rx #(.MinPreamble(8), .MaxFrameBytes(4)) dut4 (
    .Clock100Mhz(clk), .Reset(rst),
    .TIA_568B12(l12), .TIA_568B36(l36), .TIA_568B54(l54), .TIA_568B78(l78),
    .RxByte(rx_byte4), .RxValid(rx_valid4), .FrameDone(frame_done4),
    .FrameGood(frame_good4), .FrameBytes(frame_bytes4), .CodeViolations(code_viol4)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Event log sampled on the falling edge
  logic [7:0] rx_q[$];
  logic [7:0] rx_q4[$];
  int         done_n, done_n4, overlap;
  logic       good_l, good_l4;
  logic [7:0] bytes_l, bytes_l4;

  initial overlap = 0;

  always @(negedge clk) begin
    if (rx_valid) rx_q.push_back(rx_byte);
    if (rx_valid4) rx_q4.push_back(rx_byte4);
    if (frame_done) begin done_n++; good_l = frame_good; bytes_l = frame_bytes; end
    if (frame_done4) begin done_n4++; good_l4 = frame_good4; bytes_l4 = frame_bytes4; end
    if ((rx_valid && frame_done) || (rx_valid4 && frame_done4)) overlap++;
  end

  task automatic clear_log();
    rx_q.delete();
    rx_q4.delete();
    done_n = 0; done_n4 = 0;
    good_l = 1'b0; good_l4 = 1'b0;
    bytes_l = 8'hEE; bytes_l4 = 8'hEE;
  endtask

  task automatic put_raw(input logic [3:0] v);
    @(negedge clk);
    {l12, l36, l54, l78} = v;
  endtask

  task automatic put_dibit(input logic [1:0] d);
    put_raw({d[0], ~d[0], d[1], ~d[1]});
  endtask

  task automatic put_idle(input int n);
    for (int i = 0; i < n; i++) put_raw(4'b0000);
  endtask

  task automatic put_byte(input logic [7:0] b);
    for (int k = 0; k < 4; k++) put_dibit(b[2*k +: 2]);
  endtask

  task automatic put_preamble(input int n);
    for (int i = 0; i < n; i++) put_dibit(2'b01);
    put_dibit(2'b11);
  endtask

  task automatic chk_frame(input string tag, input int nrx, input int ndone,
                           input int good, input int nbytes);
    chk({tag, "_rx_count"}, rx_q.size(), nrx);
    chk({tag, "_done_count"}, done_n, ndone);
    chk({tag, "_good"}, int'(good_l), good);
    chk({tag, "_bytes"}, int'(bytes_l), nbytes);
  endtask

  task automatic good_frame(input string tag);
    clear_log();
    put_preamble(8);
    put_byte(8'h12); put_byte(8'h34); put_byte(8'h46);
    put_idle(4);
    chk_frame(tag, 3, 1, 1, 3);
    if (rx_q.size() == 3) begin
      chk({tag, "_b0"}, rx_q[0], 8'h12);
      chk({tag, "_b1"}, rx_q[1], 8'h34);
      chk({tag, "_b2"}, rx_q[2], 8'h46);
    end
  endtask

  initial begin
    {l12, l36, l54, l78} = 4'b0000;
    rst = 1'b1;
    clear_log();
    repeat (3) @(negedge clk);
    chk("rst_rxbyte", rx_byte, 0);
    chk("rst_rxvalid", rx_valid, 0);
    chk("rst_done", frame_done, 0);
    chk("rst_good", frame_good, 0);
    chk("rst_bytes", frame_bytes, 0);
    chk("rst_viol", code_viol, 0);
    rst = 1'b0;
    put_idle(2);

    // Good frame, checksum 0x12+0x34 = 0x46
    good_frame("good");
    if (rx_q4.size() == 3) chk("good4_b2", rx_q4[2], 8'h46);
    else chk("good4_rx_count", rx_q4.size(), 3);

    // Bad checksum
    clear_log();
    put_preamble(8);
    put_byte(8'h12); put_byte(8'h34); put_byte(8'h47);
    put_idle(4);
    chk_frame("badsum", 3, 1, 0, 3);
    if (rx_q.size() == 3) chk("badsum_b2", rx_q[2], 8'h47);

    // Preamble one dibit short
    clear_log();
    put_preamble(7);
    put_idle(4);
    chk_frame("shortpre", 0, 1, 0, 0);
    chk("shortpre_viol", code_viol, 0);

    // Faults while idle are not counted
    put_raw(4'b1111); put_raw(4'b1000);
    put_idle(2);
    chk("idle_fault_viol", code_viol, 0);

    // Violation on pair 12/36 at 2nd dibit of byte 2, then ignored preamble dibits
    clear_log();
    put_preamble(8);
    put_byte(8'h12);
    put_dibit(2'b00);
    put_raw(4'b1110);
    put_dibit(2'b01); put_dibit(2'b01); put_dibit(2'b11);
    put_idle(4);
    chk_frame("viol", 1, 1, 0, 1);
    chk("viol_count", code_viol, 1);
    good_frame("after_viol");

    // Byte limit on the MaxFrameBytes=4 instance
    clear_log();
    put_preamble(8);
    for (int i = 1; i <= 5; i++) put_byte(8'(i));
    put_idle(4);
    chk("max4_rx_count", rx_q4.size(), 4);
    if (rx_q4.size() == 4) chk("max4_b3", rx_q4[3], 8'h04);
    chk("max4_done_count", done_n4, 1);
    chk("max4_good", good_l4, 0);
    chk("max4_bytes", bytes_l4, 4);
    chk_frame("max64", 5, 1, 0, 5);

    // Idle after two dibits of a byte
    clear_log();
    put_preamble(8);
    put_byte(8'hA5);
    put_dibit(2'b10); put_dibit(2'b01);
    put_idle(4);
    chk_frame("partial", 1, 1, 0, 1);
    if (rx_q.size() == 1) chk("partial_b0", rx_q[0], 8'hA5);

    // Reset mid-DATA
    clear_log();
    put_preamble(8);
    put_byte(8'h5A);
    put_dibit(2'b11);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_viol", code_viol, 0);
    chk("midrst_bytes", frame_bytes, 0);
    chk("midrst_rxbyte", rx_byte, 0);
    put_dibit(2'b10);
    put_idle(1);
    rst = 1'b0;
    put_idle(3);
    chk("midrst_done_count", done_n, 0);
    good_frame("after_rst");

    chk("no_overlap", overlap, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
